// File: rtl/demux32_1to2_reg_pkg.sv
// Shared parameters and types for the two-channel registered demultiplexer.
package demux32_1to2_reg_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 16;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/demux32_1to2_reg_if.sv
// Bundle of the upstream offer, both downstream channels and the delivered-word counters.
interface demux32_1to2_reg_if
   import demux32_1to2_reg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
);

   // Handshakes: a word moves on a port in exactly the cycles where its valid and
   // ready are both high at the rising edge; valid never depends on ready, while
   // in_ready may depend combinationally on in_sel.
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out0_data;
   logic [WIDTH-1:0] out1_data;
   logic             out0_valid;
   logic             out1_valid;
   logic             out0_ready;
   logic             out1_ready;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;

   modport master (
      output in_data, in_sel, in_valid, out0_ready, out1_ready,
      input  in_ready, out0_data, out1_data, out0_valid, out1_valid, cnt0, cnt1
   );

   modport slave (
      input  in_data, in_sel, in_valid, out0_ready, out1_ready,
      output in_ready, out0_data, out1_data, out0_valid, out1_valid, cnt0, cnt1
   );

endinterface

// File: rtl/demux32_1to2_reg_slot.sv
// One output channel: a single-entry holding slot with its delivered-word counter.
module demux_slot
   import demux32_1to2_reg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_data_i,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_valid_o,
   output logic [CNT_W-1:0] cnt_o,
   output slot_state_e      state_o
);

   slot_state_e      state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hs;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   // A load in the same cycle as a drain wins, so the slot stays FULL with no bubble.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      hs      = (state_q == SLOT_FULL) && out_ready_i;
      if (hs) begin
         state_d = SLOT_EMPTY;
         cnt_d   = cnt_q + 1'b1;
      end
      if (load_i) begin
         state_d = SLOT_FULL;
         data_d  = load_data_i;
      end
   end

   assign out_data_o  = data_q;
   assign out_valid_o = (state_q == SLOT_FULL);
   assign cnt_o       = cnt_q;
   assign state_o     = state_q;

endmodule

// File: rtl/demux32_1to2_reg.sv
// Routes each accepted upstream word into one of two independently draining output slots.
module demux32_1to2_reg
   import demux32_1to2_reg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   demux32_1to2_reg_if.slave  bus
);

   logic [1:0]       out_ready;
   logic [1:0]       out_valid;
   logic [1:0]       load;
   logic             in_ready;
   logic [WIDTH-1:0] out_data [2];
   logic [CNT_W-1:0] cnt      [2];
   slot_state_e      state    [2];

   assign out_ready = {bus.out1_ready, bus.out0_ready};

   // Readiness looks only at the selected slot, so a stalled channel never blocks the other.
   always_comb begin
      in_ready = 1'b0;
      load     = 2'b00;
      if (!reset) begin
         in_ready = (state[bus.in_sel] == SLOT_EMPTY) ||
                    (out_valid[bus.in_sel] && out_ready[bus.in_sel]);
      end
      if (bus.in_valid && in_ready) begin
         load[bus.in_sel] = 1'b1;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_slot
      demux_slot #(
         .WIDTH (WIDTH),
         .CNT_W (CNT_W)
      ) u_slot (
         .clk         (clk),
         .reset       (reset),
         .load_i      (load[g]),
         .load_data_i (bus.in_data),
         .out_ready_i (out_ready[g]),
         .out_data_o  (out_data[g]),
         .out_valid_o (out_valid[g]),
         .cnt_o       (cnt[g]),
         .state_o     (state[g])
      );
   end

   assign bus.in_ready   = in_ready;
   assign bus.out0_data  = out_data[0];
   assign bus.out1_data  = out_data[1];
   assign bus.out0_valid = out_valid[0];
   assign bus.out1_valid = out_valid[1];
   assign bus.cnt0       = cnt[0];
   assign bus.cnt1       = cnt[1];

endmodule
